mac_dot_sequencer: RTL and testbench

//  Upstream feeder for the 8x8->16 MAC. Runs one dot product of length vec_len: clears the MAC,

---
 rtl/mac_dot_sequencer.sv | 131 +++++++++++++
 tb/tb_mac_dot_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer feeding a free-running 8x8->16 MAC.
// Clears the MAC, streams operand pairs, drains the pipeline, holds the result.
module mac_dot_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  mac_out,
    output logic              busy,
    output logic [ACC_W-1:0]  result,
    output logic              result_ovf,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int SUM_W  = ACC_W + LEN_W;
    localparam int DCNT_W = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    cnt;
    logic [DCNT_W-1:0]   dcnt;
    logic [SUM_W-1:0]    shadow;
    logic                accept;
    logic                last;
    logic                go;
    logic                capture;

    assign accept  = in_valid && (state == STREAM);
    assign last    = accept && (cnt == len - LEN_W'(1));
    assign go      = start && (state == IDLE);
    assign capture = (state == DRAIN) && (dcnt == DCNT_W'(MAC_LAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) state_n = CLEAR;
            end
            CLEAR: begin
                state_n = (len == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                in_ready = 1'b1;
                if (last) state_n = DRAIN;
            end
            DRAIN: begin
                if (capture) state_n = HOLD;
            end
            HOLD: begin
                if (result_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_a        <= '0;
            mac_b        <= '0;
            mac_clr      <= 1'b0;
            len          <= '0;
            cnt          <= '0;
            dcnt         <= '0;
            shadow       <= '0;
            result       <= '0;
            result_ovf   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            mac_clr <= go;
            // Zero operands on non-accept cycles keep the accumulator still.
            mac_a   <= accept ? in_a : '0;
            mac_b   <= accept ? in_b : '0;

            if (go) begin
                len    <= vec_len;
                cnt    <= '0;
                shadow <= '0;
            end else if (accept) begin
                cnt    <= cnt + LEN_W'(1);
                shadow <= shadow + SUM_W'(in_a) * SUM_W'(in_b);
            end

            if (state == DRAIN) begin
                dcnt <= dcnt + DCNT_W'(1);
            end else begin
                dcnt <= '0;
            end

            if (capture) begin
                result       <= mac_out;
                result_ovf   <= |shadow[SUM_W-1:ACC_W];
                result_valid <= 1'b1;
            end else if (state == HOLD && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural 2-cycle MAC.
// Inputs change and outputs are sampled on the falling edge.
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  vec_len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_clr;
    logic [15:0] mac_out;
    logic        busy;
    logic [15:0] result;
    logic        result_ovf;
    logic        result_valid;
    logic        result_ready;

    logic [15:0] acc;
    int          clr_cnt = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mac_dot_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vec_len      (vec_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_clr      (mac_clr),
        .mac_out      (mac_out),
        .busy         (busy),
        .result       (result),
        .result_ovf   (result_ovf),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // MAC: product accumulated one edge after the operand register,
    // visible on mac_out one edge later.
    always_ff @(posedge clk) begin
        if (rst || mac_clr) begin
            acc     <= '0;
            mac_out <= '0;
        end else begin
            acc     <= acc + 16'(mac_a) * 16'(mac_b);
            mac_out <= acc;
        end
    end

    always_ff @(posedge clk) begin
        if (mac_clr) clr_cnt <= clr_cnt + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mac_a"}, 32'(mac_a), 0);
        chk({tag, "_mac_b"}, 32'(mac_b), 0);
        chk({tag, "_clr"}, 32'(mac_clr), 0);
        chk({tag, "_rdy"}, 32'(in_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_res"}, 32'(result), 0);
        chk({tag, "_ovf"}, 32'(result_ovf), 0);
        chk({tag, "_val"}, 32'(result_valid), 0);
    endtask

    task automatic do_start(input logic [7:0] l);
        start   = 1'b1;
        vec_len = l;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send(input logic [7:0] a,
                        input logic [7:0] b,
                        input int gap);
        int w;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("gap_a", 32'(mac_a), 0);
            chk("gap_b", 32'(mac_b), 0);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("rdy_timeout", 32'(w), 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("op_a", 32'(mac_a), 32'(a));
        chk("op_b", 32'(mac_b), 32'(b));
    endtask

    task automatic wait_valid(output int c, output logic seen_rdy);
        c        = 0;
        seen_rdy = 1'b0;
        while (!result_valid && c < 20) begin
            @(negedge clk);
            seen_rdy = seen_rdy | in_ready;
            c++;
        end
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({tag, "_hs_val"}, 32'(result_valid), 0);
        chk({tag, "_hs_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int   c;
        int   base;
        logic seen;

        rst          = 1'b1;
        start        = 1'b0;
        vec_len      = '0;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1*2 + 3*4 + 5*6 + 7*8 = 100, back to back
        base = clr_cnt;
        do_start(8'd4);
        chk("t1_clr", 32'(mac_clr), 1);
        chk("t1_busy", 32'(busy), 1);
        send(8'd1, 8'd2, 0);
        send(8'd3, 8'd4, 0);
        send(8'd5, 8'd6, 0);
        send(8'd7, 8'd8, 0);
        chk("t1_rdy_drop", 32'(in_ready), 0);
        wait_valid(c, seen);
        chk("t1_latency", 32'(c), 3);
        chk("t1_result", 32'(result), 100);
        chk("t1_ovf", 32'(result_ovf), 0);
        chk("t1_clr_pulses", 32'(clr_cnt - base), 1);
        handshake("t1");

        // same vector with idle gaps
        do_start(8'd4);
        send(8'd1, 8'd2, 0);
        send(8'd3, 8'd4, 1);
        send(8'd5, 8'd6, 2);
        send(8'd7, 8'd8, 3);
        wait_valid(c, seen);
        chk("t2_latency", 32'(c), 3);
        chk("t2_result", 32'(result), 100);
        chk("t2_ovf", 32'(result_ovf), 0);
        handshake("t2");

        // empty vector: CLEAR then three DRAIN cycles
        do_start(8'd0);
        chk("t3_clr", 32'(mac_clr), 1);
        wait_valid(c, seen);
        chk("t3_latency", 32'(c), 4);
        chk("t3_rdy_seen", 32'(seen), 0);
        chk("t3_result", 32'(result), 0);
        chk("t3_ovf", 32'(result_ovf), 0);
        handshake("t3");

        // 2 * 255*255 = 130050 wraps to 64514
        do_start(8'd2);
        send(8'd255, 8'd255, 0);
        send(8'd255, 8'd255, 0);
        wait_valid(c, seen);
        chk("t4_latency", 32'(c), 3);
        chk("t4_result", 32'(result), 64514);
        chk("t4_ovf", 32'(result_ovf), 1);

        // long HOLD with a stray start
        for (int i = 0; i < 10; i++) begin
            start   = (i == 4);
            vec_len = 8'd1;
            @(negedge clk);
            chk("t5_hold_res", 32'(result), 64514);
            chk("t5_hold_val", 32'(result_valid), 1);
            chk("t5_hold_ovf", 32'(result_ovf), 1);
            chk("t5_hold_clr", 32'(mac_clr), 0);
        end
        start = 1'b0;
        handshake("t5");
        @(negedge clk);
        chk("t5_no_queue", 32'(busy), 0);
        do_start(8'd1);
        send(8'd3, 8'd3, 0);
        wait_valid(c, seen);
        chk("t5_result", 32'(result), 9);
        chk("t5_ovf", 32'(result_ovf), 0);
        handshake("t5b");

        // abort after 2 of 4 pairs
        do_start(8'd4);
        send(8'd1, 8'd2, 0);
        send(8'd3, 8'd4, 0);
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        chk_zero("t6_rst");
        rst      = 1'b0;
        in_valid = 1'b0;
        seen     = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | result_valid | busy;
        end
        chk("t6_no_result", 32'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
